mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute result (ALU value or effective address), the store data, the instruction word and the 5-bit instruction type.
- Performs word loads and stores over a req/ack data-memory port; all other types pass through.
- Presents one registered result per instruction to write-back and stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles Mem_Req_Out stays high without ack before a bus error is reported.
- IMMEDIATE_TYPE, 5'b00100, instruction type code.
- REGISTER_REGISTER_TYPE, 5'b01100, instruction type code.
- LOAD_TYPE, 5'b00000, instruction type code.
- STORE_TYPE, 5'b01000, instruction type code.
- BRANCH_TYPE, 5'b11000, instruction type code.
- MAC_TYPE, 5'b11111, instruction type code.

Ports:
- Clk_In  input  1  clock; all state updates on rising edge.
- Reset_N_In  input  1  asynchronous active-low reset.
- Valid_In  input  1  execute stage presents an instruction this cycle.
- Inst_In  input  32  instruction word.
- Inst_Type_In  input  5  instruction type (opcode[6:2]).
- Result_In  input  32  ALU result or effective address.
- Operand_B_In  input  32  store data.
- Stall_Out  output  1  upstream must hold its outputs; inputs ignored.
- Mem_Req_Out  output  1  memory request.
- Mem_We_Out  output  1  1 = store, 0 = load.
- Mem_Addr_Out  output  32  word address, [1:0] = 00.
- Mem_WData_Out  output  32  store data.
- Mem_Ack_In  input  1  memory completes request this cycle.
- Mem_RData_In  input  32  load data, valid with Mem_Ack_In.
- Valid_Out  output  1  one-cycle pulse per retired instruction.
- Inst_Out  output  32  instruction of the retired result.
- Result_Out  output  32  load data or passed-through Result_In.
- Reg_Write_Out  output  1  write-back must write rd (Inst_Out[11:7]).
- Misaligned_Out  output  1  load/store address [1:0] != 0; access suppressed.
- Bus_Error_Out  output  1  access timed out.

Behaviour:
- Reset (async, Reset_N_In low):
  - State = IDLE, timeout counter = 0.
  - All outputs 0.
  - Mem_Req_Out drops immediately, even mid-access; the in-flight instruction is discarded.
- Stall_Out = (state != IDLE), combinational from the state register. An instruction is accepted when Valid_In && state == IDLE.
- Flag outputs (Valid_Out, Misaligned_Out, Bus_Error_Out) are 0 in any cycle without a retirement. Inst_Out and Result_Out hold their last value.
- Non-memory types, accepted in IDLE:
  - Next edge: Valid_Out=1, Inst_Out=Inst_In, Result_Out=Result_In. Latency 1 cycle, full throughput.
  - Reg_Write_Out=1 for IMMEDIATE and REGISTER_REGISTER.
  - Reg_Write_Out=0 for BRANCH, MAC (reserved) and unknown types.
- Load/store accepted with Result_In[1:0] != 0:
  - No bus access.
  - Next edge: Valid_Out=1, Misaligned_Out=1, Reg_Write_Out=0, Result_Out=Result_In.
- Aligned load/store accepted:
  - Latch instruction, address and store data.
  - Next edge: state=ACCESS, Mem_Req_Out=1, Mem_We_Out=(type==STORE), Mem_Addr_Out/Mem_WData_Out driven from the latch.
  - Mem_WData_Out = 0 for loads.
- ACCESS:
  - Req, We, Addr and WData are held stable until the ack edge. Counter increments every cycle.
  - Mem_Ack_In is sampled only while Mem_Req_Out=1; ack while idle is ignored.
  - On ack: next edge Mem_Req_Out=0, state=IDLE, Valid_Out=1.
  - On ack, load: Result_Out=Mem_RData_In, Reg_Write_Out=1.
  - On ack, store: Result_Out=address, Reg_Write_Out=0.
  - Earliest ack is the first cycle Req is high, giving a 2-cycle load/store latency from acceptance.
  - Timeout: counter reaches TIMEOUT_CYCLES without ack (Req high exactly TIMEOUT_CYCLES cycles). Next edge: Req=0, state=IDLE, Valid_Out=1, Bus_Error_Out=1, Reg_Write_Out=0.
  - Ack on the same edge as the timeout: ack wins, no error.
  - Counter clears on leaving ACCESS. Width = $clog2(TIMEOUT_CYCLES+1).
- Back-to-back: the instruction presented in the cycle state returns to IDLE is accepted. No bubble beyond the access itself.
- Valid_In while Stall_Out=1 has no effect. Upstream holds it and it is accepted once IDLE.

Test Plan:
- ADD type 01100, Result_In=0x0000_0005, Valid_In for 3 consecutive cycles -> three Valid_Out pulses, each 1 cycle after its input; Reg_Write_Out=1; Result_Out=5; Stall_Out never high.
- LOAD addr 0x100, ack on the 3rd Req cycle with RData 0xDEAD_BEEF -> Stall_Out high 3 cycles; Result_Out=0xDEAD_BEEF and Reg_Write_Out=1 one edge after ack; Addr stable 0x100 throughout.
- STORE addr 0x204, data 0x1234_5678, ack in 1st Req cycle -> Mem_We_Out=1, WData=0x1234_5678; Valid_Out with Reg_Write_Out=0 two cycles after accept.
- LOAD addr 0x102 -> no Mem_Req_Out; Valid_Out+Misaligned_Out next cycle; Reg_Write_Out=0.
- LOAD with no ack, TIMEOUT_CYCLES=16 -> Req high exactly 16 cycles, then Bus_Error_Out pulse; a repeat run with ack in cycle 16 -> normal completion, no error.
- Reset_N_In low during ACCESS -> Mem_Req_Out and Stall_Out 0 immediately; after release the next instruction is accepted normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a req/ack port, everything else passes through.
// One registered result per instruction; upstream is stalled while an access is in flight.
module mem_stage #(
    parameter int         TIMEOUT_CYCLES         = 16,
    parameter logic [4:0] IMMEDIATE_TYPE         = 5'b00100,
    parameter logic [4:0] REGISTER_REGISTER_TYPE = 5'b01100,
    parameter logic [4:0] LOAD_TYPE              = 5'b00000,
    parameter logic [4:0] STORE_TYPE             = 5'b01000,
    parameter logic [4:0] BRANCH_TYPE            = 5'b11000,
    parameter logic [4:0] MAC_TYPE               = 5'b11111
) (
    input  logic        Clk_In,
    input  logic        Reset_N_In,
    input  logic        Valid_In,
    input  logic [31:0] Inst_In,
    input  logic [4:0]  Inst_Type_In,
    input  logic [31:0] Result_In,
    input  logic [31:0] Operand_B_In,
    output logic        Stall_Out,
    output logic        Mem_Req_Out,
    output logic        Mem_We_Out,
    output logic [31:0] Mem_Addr_Out,
    output logic [31:0] Mem_WData_Out,
    input  logic        Mem_Ack_In,
    input  logic [31:0] Mem_RData_In,
    output logic        Valid_Out,
    output logic [31:0] Inst_Out,
    output logic [31:0] Result_Out,
    output logic        Reg_Write_Out,
    output logic        Misaligned_Out,
    output logic        Bus_Error_Out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [31:0]    inst_lat;
    logic           accept;
    logic           is_load;
    logic           is_store;
    logic           is_mem;
    logic           aligned;
    logic           ack_seen;
    logic           timeout_hit;
    logic           writes_rd;

    assign accept      = Valid_In && (state == IDLE);
    assign is_load     = (Inst_Type_In == LOAD_TYPE);
    assign is_store    = (Inst_Type_In == STORE_TYPE);
    assign is_mem      = is_load || is_store;
    assign aligned     = (Result_In[1:0] == 2'b00);
    assign ack_seen    = Mem_Ack_In && Mem_Req_Out;
    assign cnt_inc     = cnt + CW'(1);
    assign timeout_hit = (cnt_inc == TIMEOUT_VAL);
    assign Stall_Out   = (state != IDLE);

    // Only ALU-style types write rd on pass-through; branch, MAC and unknown codes do not.
    always_comb begin
        writes_rd = 1'b0;
        case (Inst_Type_In)
            IMMEDIATE_TYPE, REGISTER_REGISTER_TYPE: writes_rd = 1'b1;
            BRANCH_TYPE, MAC_TYPE:                  writes_rd = 1'b0;
            default:                                writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mem && aligned) state_next = ACCESS;
            ACCESS:  if (ack_seen || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack takes priority over the timeout when both land on the same edge.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            cnt            <= '0;
            inst_lat       <= '0;
            Mem_Req_Out    <= 1'b0;
            Mem_We_Out     <= 1'b0;
            Mem_Addr_Out   <= '0;
            Mem_WData_Out  <= '0;
            Valid_Out      <= 1'b0;
            Inst_Out       <= '0;
            Result_Out     <= '0;
            Reg_Write_Out  <= 1'b0;
            Misaligned_Out <= 1'b0;
            Bus_Error_Out  <= 1'b0;
        end else begin
            Valid_Out      <= 1'b0;
            Reg_Write_Out  <= 1'b0;
            Misaligned_Out <= 1'b0;
            Bus_Error_Out  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        if (is_mem && aligned) begin
                            inst_lat      <= Inst_In;
                            Mem_Req_Out   <= 1'b1;
                            Mem_We_Out    <= is_store;
                            Mem_Addr_Out  <= Result_In;
                            Mem_WData_Out <= is_store ? Operand_B_In : 32'h0;
                        end else begin
                            Valid_Out      <= 1'b1;
                            Inst_Out       <= Inst_In;
                            Result_Out     <= Result_In;
                            Reg_Write_Out  <= writes_rd && !is_mem;
                            Misaligned_Out <= is_mem;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_seen) begin
                        cnt           <= '0;
                        Mem_Req_Out   <= 1'b0;
                        Mem_We_Out    <= 1'b0;
                        Valid_Out     <= 1'b1;
                        Inst_Out      <= inst_lat;
                        Result_Out    <= Mem_We_Out ? Mem_Addr_Out : Mem_RData_In;
                        Reg_Write_Out <= !Mem_We_Out;
                    end else if (timeout_hit) begin
                        cnt           <= '0;
                        Mem_Req_Out   <= 1'b0;
                        Mem_We_Out    <= 1'b0;
                        Valid_Out     <= 1'b1;
                        Inst_Out      <= inst_lat;
                        Result_Out    <= Mem_Addr_Out;
                        Bus_Error_Out <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
